// File: rtl/obi_instr_mem_responder_if.sv
// OBI instruction-fetch bus between an IF-stage initiator (master) and an
// instruction memory responder (slave).
interface obi_instr_mem_responder_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;

   modport slave (
      input  instr_req_i,
      input  instr_addr_i,
      output instr_gnt_o,
      output instr_rvalid_o,
      output instr_rdata_o,
      output instr_err_o
   );

   modport master (
      output instr_req_i,
      output instr_addr_i,
      input  instr_gnt_o,
      input  instr_rvalid_o,
      input  instr_rdata_o,
      input  instr_err_o
   );
endinterface

// File: rtl/obi_instr_mem_responder.sv
// Instruction memory responder for the OBI fetch bus. Grants requests after a
// configurable wait, answers in order after a fixed latency through a small
// response queue, flags out-of-range fetches as bus errors, and exposes a
// backdoor write port for program preload.
module obi_instr_mem_responder #(
   parameter int unsigned MEM_WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned GNT_DELAY       = 0,
   parameter int unsigned RVALID_LATENCY  = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   obi_instr_mem_responder_if.slave             bus,
   input  logic                                 stall_i,
   input  logic                                 load_we_i,
   input  logic [$clog2(MEM_WORDS)-1:0]         load_idx_i,
   input  logic [31:0]                          load_wdata_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
   localparam int unsigned OCC_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned WAIT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
   localparam int unsigned CNT_W  = (RVALID_LATENCY > 1) ? $clog2(RVALID_LATENCY) : 1;
   localparam int unsigned DEPTH  = MAX_OUTSTANDING;

   logic [31:0]                 mem [MEM_WORDS];

   logic [OCC_W-1:0]            occ;
   logic [DEPTH-1:0]            q_vld;
   logic [DEPTH-1:0]            q_vld_nxt;
   logic [DEPTH-1:0][31:0]      q_data;
   logic [DEPTH-1:0][31:0]      q_data_nxt;
   logic [DEPTH-1:0]            q_err;
   logic [DEPTH-1:0]            q_err_nxt;
   logic [DEPTH-1:0][CNT_W-1:0] q_cnt;
   logic [DEPTH-1:0][CNT_W-1:0] q_cnt_nxt;

   logic [31:0]                 off;
   logic                        in_range;
   logic [IDX_W-1:0]            idx;
   logic [31:0]                 rd_word;
   logic                        wait_ok;
   logic                        room;
   logic                        gnt;
   logic                        push;
   logic                        pop;
   logic [OCC_W-1:0]            push_slot;
   logic                        unused_off;

   // Address decode: an address below BASE_ADDR wraps to a huge offset and
   // therefore lands out of range without a separate compare.
   assign off        = bus.instr_addr_i - BASE_ADDR;
   assign in_range   = {2'b00, off[31:2]} < 32'(MEM_WORDS);
   assign idx        = off[IDX_W+1:2];
   assign rd_word    = in_range ? mem[idx] : 32'h0;
   assign unused_off = ^off[1:0];

   // The head is eligible once its countdown has drained; it pops unconditionally.
   assign pop       = q_vld[0] & (q_cnt[0] == '0);
   assign room      = (occ < OCC_W'(MAX_OUTSTANDING)) | pop;
   assign gnt       = bus.instr_req_i & ~stall_i & ~rst & wait_ok & room;
   assign push      = gnt;
   assign push_slot = pop ? (occ - 1'b1) : occ;

   assign bus.instr_gnt_o    = gnt;
   assign bus.instr_rvalid_o = pop;
   assign bus.instr_rdata_o  = pop ? q_data[0] : 32'h0;
   assign bus.instr_err_o    = pop & q_err[0];
   assign outstanding_o      = occ;

   generate
      if (GNT_DELAY == 0) begin : g_no_wait
         assign wait_ok = 1'b1;
      end else begin : g_wait
         logic [WAIT_W-1:0] wait_cnt;

         // Count ungranted request cycles up to GNT_DELAY; stall does not clear it.
         always_ff @(posedge clk) begin
            if (rst) begin
               wait_cnt <= '0;
            end else if (gnt || !bus.instr_req_i) begin
               wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(GNT_DELAY)) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end

         assign wait_ok = (wait_cnt == WAIT_W'(GNT_DELAY));
      end
   endgenerate

   // Next queue image: shift out the popped head, age every countdown, then
   // append the new entry behind the last occupied slot.
   always_comb begin
      q_vld_nxt  = q_vld;
      q_data_nxt = q_data;
      q_err_nxt  = q_err;
      q_cnt_nxt  = q_cnt;
      if (pop) begin
         q_vld_nxt  = q_vld >> 1;
         q_data_nxt = q_data >> 32;
         q_err_nxt  = q_err >> 1;
         q_cnt_nxt  = q_cnt >> CNT_W;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (q_cnt_nxt[i] != '0) begin
            q_cnt_nxt[i] = q_cnt_nxt[i] - 1'b1;
         end
         if (push && (OCC_W'(i) == push_slot)) begin
            q_vld_nxt[i]  = 1'b1;
            q_data_nxt[i] = rd_word;
            q_err_nxt[i]  = ~in_range;
            q_cnt_nxt[i]  = CNT_W'(RVALID_LATENCY - 1);
         end
      end
   end

   // Queue payload registers; valid bits gate them, so they need no reset.
   always_ff @(posedge clk) begin
      q_data <= q_data_nxt;
      q_err  <= q_err_nxt;
      q_cnt  <= q_cnt_nxt;
   end

   // Queue valid bits and occupancy; reset discards every pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_vld <= '0;
         occ   <= '0;
      end else begin
         q_vld <= q_vld_nxt;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Backdoor program load; the fetch read above sees the old word this cycle.
   always_ff @(posedge clk) begin
      if (load_we_i) begin
         mem[load_idx_i] <= load_wdata_i;
      end
   end

endmodule
